// File: rtl/pipe_pkg.sv
// Shared state type and payload layout for the inter-stage pipeline registers.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } pipe_state_e;

  // Decode/exec boundary payload
  localparam int DE_DATA_W = 128;
  localparam int DE_CTRL_W = 35;

  localparam int DE_CTRL_LSB    = 0;
  localparam int DE_RD_LSB      = 35;
  localparam int DE_RD_W        = 5;
  localparam int DE_RD_DATA_LSB = 40;
  localparam int DE_RD_DATA_W   = 16;
  localparam int DE_RS_DATA_LSB = 56;
  localparam int DE_RS_DATA_W   = 16;
  localparam int DE_SHAMT_LSB   = 72;
  localparam int DE_SHAMT_W     = 5;
  localparam int DE_IMM_LSB     = 77;
  localparam int DE_IMM_W       = 12;
  localparam int DE_RS_LSB      = 89;
  localparam int DE_RS_W        = 5;
  localparam int DE_INT1_LSB    = 94;
  localparam int DE_INT2_LSB    = 95;
  localparam int DE_PC_LSB      = 96;
  localparam int DE_PC_W        = 32;

endpackage

// File: rtl/pipe_perf_cnt.sv
// Saturating event counter used for pipeline stage performance monitoring.
module pipe_perf_cnt #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with two-entry skid buffer, flush and control-field bubble gating.
// Optional perf counters are built when PIPE_STAGE_REG_PERF_EN is defined.
//
// state | meaning
// EMPTY | no valid entries
// ONE   | main valid
// TWO   | main and skid valid
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                DATA_W    = 128,
  parameter int                CTRL_W    = 35,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready
`ifdef PIPE_STAGE_REG_PERF_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       full_cnt,
  output logic [15:0]       flush_cnt
`endif
);

  // Shifting by DATA_W yields an empty mask, so CTRL_W=0 disables gating.
  localparam logic [DATA_W-1:0] CTRL_MASK = {DATA_W{1'b1}} >> (DATA_W - CTRL_W);

  pipe_state_e       state, state_nxt;
  logic [DATA_W-1:0] main_q, main_nxt;
  logic [DATA_W-1:0] skid_q, skid_nxt;
  logic              in_fire, out_fire;

  assign in_ready  = (state != TWO);
  assign out_valid = (state != EMPTY);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign out_data  = out_valid ? main_q : (main_q & ~CTRL_MASK);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= EMPTY;
      main_q <= RESET_VAL;
      skid_q <= RESET_VAL;
    end else begin
      state  <= state_nxt;
      main_q <= main_nxt;
      skid_q <= skid_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    main_nxt  = main_q;
    skid_nxt  = skid_q;
    if (flush) begin
      state_nxt = EMPTY;
      main_nxt  = RESET_VAL;
      skid_nxt  = RESET_VAL;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            main_nxt  = in_data;
            state_nxt = ONE;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_nxt = in_data;
          end else if (in_fire) begin
            skid_nxt  = in_data;
            state_nxt = TWO;
          end else if (out_fire) begin
            state_nxt = EMPTY;
          end
        end
        TWO: begin
          if (out_fire) begin
            main_nxt  = skid_q;
            state_nxt = ONE;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

`ifdef PIPE_STAGE_REG_PERF_EN
  pipe_perf_cnt #(.W(32)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (out_valid & ~out_ready),
    .cnt   (stall_cnt)
  );

  pipe_perf_cnt #(.W(32)) u_full_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (state == TWO),
    .cnt   (full_cnt)
  );

  pipe_perf_cnt #(.W(16)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (flush),
    .cnt   (flush_cnt)
  );
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: queue-based reference model plus directed scenarios.
// Perf counter checks are included when PIPE_STAGE_REG_PERF_EN is defined.
module tb_pipe_stage_reg;

  localparam int DW = 128;
  localparam int CW = 35;

  logic          clk       = 1'b0;
  logic          rst_n     = 1'b1;
  logic          flush     = 1'b0;
  logic          in_valid  = 1'b0;
  logic          out_ready = 1'b0;
  logic [DW-1:0] in_data   = '0;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
`ifdef PIPE_STAGE_REG_PERF_EN
  logic [31:0]   stall_cnt;
  logic [31:0]   full_cnt;
  logic [15:0]   flush_cnt;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(
    .DATA_W    (DW),
    .CTRL_W    (CW),
    .RESET_VAL ('0)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready)
`ifdef PIPE_STAGE_REG_PERF_EN
    ,
    .stall_cnt (stall_cnt),
    .full_cnt  (full_cnt),
    .flush_cnt (flush_cnt)
`endif
  );

  task automatic check1(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic checkd(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: FIFO of held payloads (max two) plus the last payload presented.
  logic [DW-1:0] q[$];
  logic [DW-1:0] last_main = '0;
  longint        m_stall = 0, m_full = 0, m_flush = 0;
  bit            m_in, m_out;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      last_main = '0;
      m_stall = 0;
      m_full  = 0;
      m_flush = 0;
    end else begin
      if (q.size() > 0 && !out_ready) m_stall++;
      if (q.size() == 2) m_full++;
      if (flush) m_flush++;
      m_out = (q.size() > 0) && out_ready;
      m_in  = in_valid && (q.size() < 2);
      if (flush) begin
        q.delete();
        last_main = '0;
      end else begin
        if (m_out) last_main = q.pop_front();
        if (m_in) q.push_back(in_data);
      end
    end
  end

  function automatic logic [DW-1:0] exp_data();
    logic [DW-1:0] m;
    if (q.size() > 0) return q[0];
    m = last_main;
    m[CW-1:0] = '0;
    return m;
  endfunction

  always @(negedge clk) begin
    check1("model_in_ready", in_ready, q.size() < 2);
    check1("model_out_valid", out_valid, q.size() > 0);
    checkd("model_out_data", out_data, exp_data());
`ifdef PIPE_STAGE_REG_PERF_EN
    checkd("model_stall_cnt", DW'(stall_cnt), DW'((m_stall > 64'hFFFFFFFF) ? 64'hFFFFFFFF : m_stall));
    checkd("model_full_cnt", DW'(full_cnt), DW'((m_full > 64'hFFFFFFFF) ? 64'hFFFFFFFF : m_full));
    checkd("model_flush_cnt", DW'(flush_cnt), DW'((m_flush > 64'hFFFF) ? 64'hFFFF : m_flush));
`endif
  end

  logic [DW-1:0] ones;

  initial begin
    ones = '1;
    #1 rst_n = 1'b0;
    #2;
    check1("reset_out_valid", out_valid, 1'b0);
    check1("reset_in_ready", in_ready, 1'b1);
    checkd("reset_out_data", out_data, 128'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // streaming at full throughput
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 128'h1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      checkd("stream_data", out_data, DW'(i));
      check1("stream_in_ready", in_ready, 1'b1);
      if (i < 8) in_data = DW'(i + 1);
      else in_valid = 1'b0;
    end
    @(negedge clk);
    check1("stream_drained", out_valid, 1'b0);

    // backpressure fills the skid entry
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 128'hA1;
    @(negedge clk);
    in_data = 128'hA2;
    @(negedge clk);
    in_valid = 1'b0;
    check1("bp_in_ready_low", in_ready, 1'b0);
    checkd("bp_head", out_data, 128'hA1);
    @(negedge clk);
    checkd("bp_hold", out_data, 128'hA1);
    check1("bp_valid", out_valid, 1'b1);
    out_ready = 1'b1;
    @(negedge clk);
    checkd("bp_second", out_data, 128'hA2);
    check1("bp_in_ready_back", in_ready, 1'b1);
    @(negedge clk);
    check1("bp_empty", out_valid, 1'b0);

    // flush collides with an incoming beat
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 128'hB1;
    @(negedge clk);
    checkd("flush_pre", out_data, 128'hB1);
    flush   = 1'b1;
    in_data = 128'hB2;
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    check1("flush_valid", out_valid, 1'b0);
    checkd("flush_data", out_data, 128'h0);
    out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check1("flush_no_b2", out_valid, 1'b0);
    end

    // bubble gating keeps upper bits, zeroes the control field
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = ones;
    @(negedge clk);
    in_valid = 1'b0;
    checkd("bubble_full", out_data, ones);
    out_ready = 1'b1;
    @(negedge clk);
    check1("bubble_valid", out_valid, 1'b0);
    checkd("bubble_data", out_data, ones << CW);

    // asynchronous reset while holding two entries
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 128'hC1;
    @(negedge clk);
    in_data = 128'hC2;
    @(negedge clk);
    in_valid = 1'b0;
    check1("rst_pre_two", in_ready, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check1("rst_async_valid", out_valid, 1'b0);
    check1("rst_async_ready", in_ready, 1'b1);
    checkd("rst_async_data", out_data, 128'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check1("rst_after_empty", out_valid, 1'b0);

`ifdef PIPE_STAGE_REG_PERF_EN
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 128'hD1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    out_ready = 1'b1;
    flush     = 1'b1;
    @(negedge clk);
    @(negedge clk);
    flush = 1'b0;
    checkd("perf_stall", DW'(stall_cnt), 128'd5);
    checkd("perf_flush", DW'(flush_cnt), 128'd2);
    checkd("perf_full", DW'(full_cnt), 128'd0);
`endif

    // randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(3) != 0);
      in_data   = {$urandom(), $urandom(), $urandom(), $urandom()};
      out_ready = ($urandom_range(2) != 0);
      flush     = ($urandom_range(31) == 0);
      @(negedge clk);
    end
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised inter-stage pipeline register that replaces the fixed-width, fixed-field stage latches; one instance per stage boundary (fetch/decode, decode/exec, exec/mem, mem/wb).
- Carries an opaque DATA_W payload with a valid/ready handshake.
- A two-entry skid buffer gives full throughput under backpressure.
- Provides a synchronous flush, and forces a control-field bubble when the output is empty.

Parameters:
- DATA_W, 128: total payload width in bits.
- CTRL_W, 35: width of the control field in payload bits [CTRL_W-1:0]; forced to zero when out_valid=0. Legal range 0..DATA_W; 0 disables bubble gating.
- RESET_VAL, 0: reset/flush value of both storage entries (DATA_W bits).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous squash of all held entries (branch/interrupt redirect).
- in_valid  in  1  upstream has a payload.
- in_data  in  DATA_W  upstream payload.
- in_ready  out  1  block can accept this cycle.
- out_valid  out  1  payload at out_data is valid.
- out_data  out  DATA_W  downstream payload; control field is bubble-gated.
- out_ready  in  1  downstream accepts this cycle.

Behaviour:
- Handshake events: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Storage: main entry (drives out_data) and skid entry, each with its own valid bit.
- States:
  - EMPTY: no valid entries.
  - ONE: main valid.
  - TWO: main and skid valid.
- Reset (rst_n low, asynchronous):
  - state=EMPTY; main=skid=RESET_VAL.
  - out_valid=0; in_ready=1; out_data control field=0.
- Outputs are registered or derived from state only; no combinational in→out path.
  - in_ready = (state != TWO).
  - out_valid = (state != EMPTY).
  - in_ready never depends on out_ready.
- Transitions when flush=0:
  - EMPTY: in_fire → main<=in_data, go to ONE. Otherwise stay in EMPTY.
  - ONE, in_fire & out_fire: main<=in_data, stay in ONE.
  - ONE, in_fire & !out_fire: skid<=in_data, go to TWO.
  - ONE, !in_fire & out_fire: go to EMPTY.
  - ONE, neither: hold.
  - TWO: in_ready=0.
    - out_fire → main<=skid, go to ONE.
    - Otherwise hold.
- Latency: payload accepted on edge N appears at out_data with out_valid=1 after edge N. Throughput is 1 per cycle when out_ready is held high.
- Ordering: strictly FIFO; the skid entry is never presented before main.
- flush=1 on an edge:
  - Overrides everything: state<=EMPTY, both entries<=RESET_VAL.
  - Any same-cycle in_fire is discarded.
  - A same-cycle out_fire still counts downstream; flush does not suppress the current output.
- Bubble gating: out_data[CTRL_W-1:0] = out_valid ? main[CTRL_W-1:0] : 0. Upper bits pass main unchanged.
- Hold stability: while out_valid=1 and out_ready=0, out_data is bit-stable.
- Reset asserted mid-transfer: all state is lost immediately and asynchronously. No partial update survives.
- Deassertion of rst_n is synchronised upstream; this block does not re-synchronise it.

Optional Feature:
- Macro: PIPE_STAGE_REG_PERF_EN.
- When defined, the block adds three outputs:
  - stall_cnt [31:0]: increments each cycle with out_valid & !out_ready.
  - full_cnt [31:0]: increments each cycle in state TWO.
  - flush_cnt [15:0]: increments on each flush=1 edge.
- All three counters are saturating, reset to 0 by rst_n, and are not cleared by flush.
- When undefined, these ports and counters do not exist; the datapath is identical in both builds.

Decomposition:
- Shared package pipe_pkg:
  - State enum {EMPTY, ONE, TWO}.
  - Per-boundary width constants, e.g. DE_CTRL_W=35 and DE_DATA_W=128.
  - Field-offset localparams for the decode/exec payload: ctrl, rd, rd_data, rs_data, shamt, imm, rs, int1, int2, pc.
- Sub-module pipe_perf_cnt: a single saturating counter parameterised by width, instantiated three times under the macro.
- The main block contains no other sub-modules.

Test Plan:
- Reset: rst_n=0 mid-run with state TWO → out_valid=0, in_ready=1, out_data=0 immediately without a clock edge; after release, EMPTY.
- Streaming: out_ready=1, inputs 0x01..0x08 on consecutive cycles → out_data 0x01..0x08 one cycle later each, in_ready always 1.
- Backpressure: load 0xA1, 0xA2 with out_ready=0 → state TWO, in_ready=0, out_data=0xA1 stable. Raise out_ready → 0xA1 then 0xA2, in_ready=1 after the first out_fire.
- Flush collision: state ONE with 0xB1, flush=1 with in_valid=1 in_data=0xB2 → next cycle out_valid=0, 0xB2 never emitted, control bits 0.
- Bubble gating: CTRL_W=35, main holds all-ones; after out_fire with no new input → out_data[34:0]=0, out_data[127:35] unchanged.
- Perf (macro on): 5 stall cycles and 2 flushes → stall_cnt=5, flush_cnt=2; counter at 0xFFFFFFFF stays there on further stalls.
